// File: rtl/tcdm_resp_pkg.sv
// Shared types and constants for the L2 TCDM responder (l2_tcdm_responder).
package tcdm_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_e;

    // Returned on out-of-range accesses when range checking is built in.
    localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

    localparam int unsigned MAX_WAIT_CYCLES = 15;

    // Wait-state counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        return (wait_cycles == 0) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/tcdm_addr_decode.sv
// Combinational byte-address decode for one L2 bank: base subtract, word
// index extraction and in-range flag.
module tcdm_addr_decode
    import tcdm_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1C00_0000,
    parameter int unsigned MEM_WORDS = 16384
) (
    input  logic [31:0]                  addr_i,
    output logic [$clog2(MEM_WORDS)-1:0] word_idx_o,
    output logic                         in_range_o
);

    localparam int unsigned AW    = $clog2(MEM_WORDS);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'd4;

    // Byte-offset bits [1:0] fall away in the shift; upper bits wrap the bank.
    assign word_idx_o = AW'((addr_i - BASE_ADDR) >> 2);
    assign in_range_o = (addr_i >= BASE_ADDR) && ({1'b0, addr_i} < LIMIT);

endmodule

// File: rtl/l2_tcdm_responder.sv
// TCDM responder in front of one single-port, 1-cycle-latency L2 SRAM bank.
// Optional macro TCDM_RESP_RANGE_CHECK_EN: flag out-of-range accesses via r_opc_o.
module l2_tcdm_responder
    import tcdm_resp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1C00_0000,
    parameter int unsigned MEM_WORDS   = 16384,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_i,
    input  logic [31:0]                  add_i,
    input  logic                         wen_i,
    input  logic [31:0]                  wdata_i,
    input  logic [3:0]                   be_i,
    output logic                         gnt_o,
    output logic                         r_valid_o,
    output logic [31:0]                  r_rdata_o,
    output logic                         r_opc_o,
    output logic                         mem_req_o,
    output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
    output logic                         mem_we_o,
    output logic [3:0]                   mem_be_o,
    output logic [31:0]                  mem_wdata_o,
    input  logic [31:0]                  mem_rdata_i
);

    localparam int unsigned   AW       = $clog2(MEM_WORDS);
    localparam int unsigned   CW       = cnt_width(WAIT_CYCLES);
    localparam bit            NO_WAIT  = (WAIT_CYCLES == 0);
    localparam logic [CW-1:0] CNT_LOAD = NO_WAIT ? '0 : CW'(WAIT_CYCLES - 1);

    resp_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gnt;
    logic          access;

    logic [31:0]   add_q;
    logic          wen_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;

    logic [31:0]   dec_addr;
    logic [AW-1:0] word_idx;
    logic          in_range;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 1'b0;
        access  = 1'b0;
        unique case (state_q)
            IDLE, RESP: begin
                gnt    = req_i & ~rst_i;
                access = gnt & NO_WAIT;
                if (gnt) begin
                    state_d = NO_WAIT ? RESP : WAIT;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    access  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            add_q   <= '0;
            wen_q   <= 1'b1;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (gnt) begin
            add_q   <= add_i;
            wen_q   <= wen_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
        end
    end

    // Zero-wait builds hit the SRAM in the grant cycle, so decode the live inputs.
    assign dec_addr = NO_WAIT ? add_i : add_q;

    tcdm_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .MEM_WORDS (MEM_WORDS)
    ) u_addr_decode (
        .addr_i     (dec_addr),
        .word_idx_o (word_idx),
        .in_range_o (in_range)
    );

    assign gnt_o       = gnt;
    assign mem_addr_o  = word_idx;
    assign mem_we_o    = NO_WAIT ? ~wen_i   : ~wen_q;
    assign mem_be_o    = NO_WAIT ? be_i     : be_q;
    assign mem_wdata_o = NO_WAIT ? wdata_i  : wdata_q;

`ifdef TCDM_RESP_RANGE_CHECK_EN
    logic err_q;

    // Captured at the access cycle so the flag belongs to the request being answered.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (access) begin
            err_q <= ~in_range;
        end
    end

    assign mem_req_o = access & in_range;

    always_comb begin
        r_valid_o = (state_q == RESP);
        r_opc_o   = r_valid_o & err_q;
        r_rdata_o = '0;
        if (r_valid_o) begin
            if (err_q) begin
                r_rdata_o = ERR_RDATA;
            end else if (wen_q) begin
                r_rdata_o = mem_rdata_i;
            end
        end
    end
`else
    logic unused_in_range;
    assign unused_in_range = in_range;

    assign mem_req_o = access;

    always_comb begin
        r_valid_o = (state_q == RESP);
        r_opc_o   = 1'b0;
        r_rdata_o = '0;
        if (r_valid_o && wen_q) begin
            r_rdata_o = mem_rdata_i;
        end
    end
`endif

endmodule

// File: tb/tb_l2_tcdm_responder.sv
// Bench for l2_tcdm_responder: three instances (0, 2 and 3 wait states), each with
// its own SRAM model, checked against a word-addressed reference memory.
module tb_l2_tcdm_responder;

    localparam logic [31:0] BASE      = 32'h1C00_0000;
    localparam int unsigned MEM_WORDS = 16384;
    localparam int unsigned AW        = 14;
    localparam logic [31:0] ERR       = 32'hBADACCE5;
`ifdef TCDM_RESP_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req    [3];
    logic [31:0]   add    [3];
    logic          wen    [3];
    logic [31:0]   wdata  [3];
    logic [3:0]    be     [3];
    logic          gnt    [3];
    logic          rvalid [3];
    logic [31:0]   rdata  [3];
    logic          opc    [3];
    logic          mreq   [3];
    logic [AW-1:0] maddr  [3];
    logic          mwe    [3];
    logic [3:0]    mbe    [3];
    logic [31:0]   mwdata [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] sram [MEM_WORDS];
        logic [31:0] mrdata;

        l2_tcdm_responder #(
            .BASE_ADDR   (BASE),
            .MEM_WORDS   (MEM_WORDS),
            .WAIT_CYCLES ((g == 0) ? 0 : g + 1)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .req_i       (req[g]),
            .add_i       (add[g]),
            .wen_i       (wen[g]),
            .wdata_i     (wdata[g]),
            .be_i        (be[g]),
            .gnt_o       (gnt[g]),
            .r_valid_o   (rvalid[g]),
            .r_rdata_o   (rdata[g]),
            .r_opc_o     (opc[g]),
            .mem_req_o   (mreq[g]),
            .mem_addr_o  (maddr[g]),
            .mem_we_o    (mwe[g]),
            .mem_be_o    (mbe[g]),
            .mem_wdata_o (mwdata[g]),
            .mem_rdata_i (mrdata)
        );

        always @(posedge clk) begin
            if (mreq[g]) begin
                if (mwe[g]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mbe[g][b]) sram[maddr[g]][8*b +: 8] <= mwdata[g][8*b +: 8];
                    end
                end else begin
                    mrdata <= sram[maddr[g]];
                end
            end
        end
    end

    int errors = 0;
    int checks = 0;

    // Reference model: plain word-addressed memory per instance.
    logic [31:0] ref_mem [int];

    function automatic int wc(input int g);
        return (g == 0) ? 0 : g + 1;
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * longint'(MEM_WORDS));
    endfunction

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off / 4) % MEM_WORDS);
    endfunction

    function automatic logic [31:0] ref_rd(input int g, input logic [31:0] a);
        int key;
        key = g * MEM_WORDS + word_of(a);
        return ref_mem.exists(key) ? ref_mem[key] : 32'h0;
    endfunction

    task automatic ref_wr(input int g, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] w;
        w = ref_rd(g, a);
        for (int i = 0; i < 4; i++) if (b[i]) w[8*i +: 8] = d[8*i +: 8];
        ref_mem[g * MEM_WORDS + word_of(a)] = w;
    endtask

    // Observations of the last transaction, offsets relative to the grant cycle.
    int          o_t0, o_mreq, o_nreq, o_rv, o_gnt_extra;
    logic [31:0] o_rdata, o_mwdata;
    logic        o_opc, o_mwe, o_leak;
    logic [AW-1:0] o_maddr;
    logic [3:0]  o_mbe;

    task automatic txn(input int g, input logic [31:0] a, input logic w, input logic [31:0] wd,
                       input logic [3:0] b, input bit hold);
        bit done;
        done = 0;
        o_t0 = -1; o_mreq = -1; o_nreq = 0; o_rv = -1; o_gnt_extra = 0;
        o_rdata = 'x; o_opc = 1'bx; o_leak = 0; o_maddr = '0; o_mwe = 0; o_mbe = '0; o_mwdata = '0;
        @(posedge clk); #1;
        req[g] = 1; add[g] = a; wen[g] = w; wdata[g] = wd; be[g] = b;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (o_t0 < 0 && gnt[g]) o_t0 = k;
            else if (o_t0 >= 0 && gnt[g]) o_gnt_extra++;
            if (o_t0 >= 0) begin
                if (mreq[g]) begin
                    o_nreq++; o_mreq = k - o_t0;
                    o_maddr = maddr[g]; o_mwe = mwe[g]; o_mbe = mbe[g]; o_mwdata = mwdata[g];
                end
                if (rvalid[g]) begin
                    o_rv = k - o_t0; o_rdata = rdata[g]; o_opc = opc[g]; done = 1;
                end else if (rdata[g] !== 32'h0 || opc[g] !== 1'b0) begin
                    o_leak = 1;
                end
            end
            if (!done) begin
                @(posedge clk); #1;
                if (o_t0 >= 0) req[g] = hold && ((k - o_t0) < wc(g));
            end
        end
        req[g] = 0;
    endtask

    task automatic test_reset();
        for (int g = 0; g < 3; g++) begin req[g] = 1; add[g] = BASE; wen[g] = 0; wdata[g] = '1; be[g] = '1; end
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            checks++; if (gnt[g] !== 1'b0) begin errors++; $display("FAIL rst_gnt[%0d]: got %b want 0", g, gnt[g]); end
            checks++; if (rvalid[g] !== 1'b0) begin errors++; $display("FAIL rst_rvalid[%0d]: got %b want 0", g, rvalid[g]); end
            checks++; if (rdata[g] !== 32'h0) begin errors++; $display("FAIL rst_rdata[%0d]: got %h want 0", g, rdata[g]); end
            checks++; if (opc[g] !== 1'b0) begin errors++; $display("FAIL rst_opc[%0d]: got %b want 0", g, opc[g]); end
            checks++; if (mreq[g] !== 1'b0) begin errors++; $display("FAIL rst_mreq[%0d]: got %b want 0", g, mreq[g]); end
            req[g] = 0;
        end
        @(posedge clk); #1; rst = 0;
    endtask

    task automatic test_basic();
        logic [31:0] t_d  [4] = '{32'hDEADBEEF, 32'h0, 32'h0000AB00, 32'h0};
        logic [3:0]  t_be [4] = '{4'hF, 4'hF, 4'b0010, 4'hF};
        logic        t_w  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] t_rd [4] = '{32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADABEF};
        for (int i = 0; i < 4; i++) begin
            txn(0, 32'h1C00_0010, t_w[i], t_d[i], t_be[i], 0);
            if (!t_w[i]) ref_wr(0, 32'h1C00_0010, t_d[i], t_be[i]);
            checks++; if (o_t0 !== 0) begin errors++; $display("FAIL basic%0d_gnt: got %0d want 0", i, o_t0); end
            checks++; if (o_mreq !== 0 || o_nreq !== 1) begin errors++; $display("FAIL basic%0d_mreq: got at %0d x%0d want at 0 x1", i, o_mreq, o_nreq); end
            checks++; if (o_maddr !== 14'd4) begin errors++; $display("FAIL basic%0d_maddr: got %0d want 4", i, o_maddr); end
            checks++; if (o_mwe !== ~t_w[i] || o_mbe !== t_be[i]) begin errors++; $display("FAIL basic%0d_wbe: got we=%b be=%h want we=%b be=%h", i, o_mwe, o_mbe, ~t_w[i], t_be[i]); end
            checks++; if (o_rv !== 1) begin errors++; $display("FAIL basic%0d_rv: got %0d want 1", i, o_rv); end
            checks++; if (o_rdata !== t_rd[i] || o_opc !== 1'b0) begin errors++; $display("FAIL basic%0d_rdata: got %h/%b want %h/0", i, o_rdata, o_opc, t_rd[i]); end
        end
    endtask

    task automatic test_wait();
        logic [31:0] d;
        for (int g = 1; g < 3; g++) begin
            d = $urandom;
            txn(g, BASE + 32'h14, 0, d, 4'hF, 0);
            ref_wr(g, BASE + 32'h14, d, 4'hF);
            checks++; if (o_mreq !== wc(g) || o_rv !== wc(g) + 1) begin errors++; $display("FAIL wait%0d_wr_lat: got mreq %0d rv %0d want %0d %0d", g, o_mreq, o_rv, wc(g), wc(g) + 1); end
            txn(g, BASE + 32'h14, 1, 32'h0, 4'hF, 1);
            checks++; if (o_t0 !== 0) begin errors++; $display("FAIL wait%0d_gnt: got %0d want 0", g, o_t0); end
            checks++; if (o_gnt_extra !== 0) begin errors++; $display("FAIL wait%0d_gnt_held: got %0d grants want 0", g, o_gnt_extra); end
            checks++; if (o_mreq !== wc(g) || o_nreq !== 1) begin errors++; $display("FAIL wait%0d_mreq: got at %0d x%0d want at %0d x1", g, o_mreq, o_nreq, wc(g)); end
            checks++; if (o_rv !== wc(g) + 1) begin errors++; $display("FAIL wait%0d_rv: got %0d want %0d", g, o_rv, wc(g) + 1); end
            checks++; if (o_rdata !== d || o_leak !== 1'b0) begin errors++; $display("FAIL wait%0d_rdata: got %h leak %b want %h leak 0", g, o_rdata, o_leak, d); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [31:0] got [$];
        logic [5:0]  rv_mask;
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            txn(0, BASE + 4 * i, 0, d, 4'hF, 0);
            ref_wr(0, BASE + 4 * i, d, 4'hF);
        end
        rv_mask = '0;
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            if (k < 3) begin req[0] = 1; add[0] = BASE + 4 * k; wen[0] = 1; be[0] = 4'hF; end
            else req[0] = 0;
            @(negedge clk);
            if (k < 3) begin
                checks++; if (gnt[0] !== 1'b1) begin errors++; $display("FAIL b2b_gnt%0d: got %b want 1", k, gnt[0]); end
                checks++; if (mreq[0] !== 1'b1 || maddr[0] !== AW'(k)) begin errors++; $display("FAIL b2b_mreq%0d: got %b @%0d want 1 @%0d", k, mreq[0], maddr[0], k); end
            end
            if (rvalid[0]) begin rv_mask[k] = 1'b1; got.push_back(rdata[0]); end
            @(posedge clk); #1;
        end
        req[0] = 0;
        checks++; if (rv_mask !== 6'b001110) begin errors++; $display("FAIL b2b_rv_pattern: got %b want 001110", rv_mask); end
        for (int i = 0; i < 3; i++) begin
            d = (got.size() > 0) ? got.pop_front() : 32'hx;
            checks++; if (d !== ref_rd(0, BASE + 4 * i)) begin errors++; $display("FAIL b2b_data%0d: got %h want %h", i, d, ref_rd(0, BASE + 4 * i)); end
        end
    endtask

    task automatic test_range();
        logic [31:0] addrs [3] = '{32'h1C01_0000, 32'h1BFF_FFFC, 32'h1C01_0046};
        logic [31:0] d, exp;
        bit hit;
        for (int g = 0; g < 3; g += 2) begin
            foreach (addrs[i]) begin
                hit = !RC || in_rng(addrs[i]);
                d = $urandom;
                txn(g, addrs[i], 0, d, 4'hF, 0);
                if (hit) ref_wr(g, addrs[i], d, 4'hF);
                checks++; if (o_nreq !== int'(hit) || o_rv !== wc(g) + 1) begin errors++; $display("FAIL range%0d_%0d_wr: got nreq %0d rv %0d want %0d %0d", g, i, o_nreq, o_rv, hit, wc(g) + 1); end
                exp = hit ? 32'h0 : ERR;
                checks++; if (o_rdata !== exp || o_opc !== !hit) begin errors++; $display("FAIL range%0d_%0d_wr_rsp: got %h/%b want %h/%b", g, i, o_rdata, o_opc, exp, !hit); end
                txn(g, addrs[i], 1, 32'h0, 4'hF, 0);
                exp = hit ? ref_rd(g, addrs[i]) : ERR;
                checks++; if (o_nreq !== int'(hit) || o_rv !== wc(g) + 1) begin errors++; $display("FAIL range%0d_%0d_rd: got nreq %0d rv %0d want %0d %0d", g, i, o_nreq, o_rv, hit, wc(g) + 1); end
                checks++; if (o_rdata !== exp || o_opc !== !hit) begin errors++; $display("FAIL range%0d_%0d_rd_rsp: got %h/%b want %h/%b", g, i, o_rdata, o_opc, exp, !hit); end
                if (o_nreq == 1) begin
                    checks++; if (o_maddr !== AW'(word_of(addrs[i]))) begin errors++; $display("FAIL range%0d_%0d_maddr: got %0d want %0d", g, i, o_maddr, word_of(addrs[i])); end
                end
            end
        end
    endtask

    task automatic test_random();
        int g, k;
        logic [31:0] a, d, exp;
        logic [3:0] b;
        logic w;
        bit hit;
        for (int gg = 0; gg < 3; gg++) begin
            for (int i = 0; i < 16; i++) begin
                d = $urandom;
                txn(gg, BASE + 4 * i, 0, d, 4'hF, 0);
                ref_wr(gg, BASE + 4 * i, d, 4'hF);
            end
        end
        for (int n = 0; n < 60; n++) begin
            g = $urandom_range(0, 2);
            k = $urandom_range(0, 15);
            a = (($urandom_range(0, 4) == 0) ? BASE + 4 * MEM_WORDS : BASE) + 4 * k + $urandom_range(0, 3);
            w = 1'($urandom);
            d = $urandom;
            b = 4'($urandom);
            hit = !RC || in_rng(a);
            exp = !hit ? ERR : (w ? ref_rd(g, a) : 32'h0);
            txn(g, a, w, d, b, 0);
            if (hit && !w) ref_wr(g, a, d, b);
            checks++; if (o_t0 !== 0 || o_rv !== wc(g) + 1) begin errors++; $display("FAIL rnd%0d_lat: got gnt %0d rv %0d want 0 %0d", n, o_t0, o_rv, wc(g) + 1); end
            checks++; if (o_nreq !== int'(hit)) begin errors++; $display("FAIL rnd%0d_nreq: got %0d want %0d", n, o_nreq, hit); end
            checks++; if (o_rdata !== exp || o_opc !== !hit || o_leak !== 1'b0) begin errors++; $display("FAIL rnd%0d_rsp: got %h/%b leak %b want %h/%b", n, o_rdata, o_opc, o_leak, exp, !hit); end
            if (o_nreq == 1) begin
                checks++; if (o_mreq !== wc(g) || o_maddr !== AW'(word_of(a)) || o_mwe !== !w) begin errors++; $display("FAIL rnd%0d_mem: got at %0d @%0d we %b want at %0d @%0d we %b", n, o_mreq, o_maddr, o_mwe, wc(g), word_of(a), !w); end
                if (!w) begin
                    checks++; if (o_mbe !== b || o_mwdata !== d) begin errors++; $display("FAIL rnd%0d_wdata: got %h/%h want %h/%h", n, o_mbe, o_mwdata, b, d); end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen_rv, seen_mreq;
        @(posedge clk); #1;
        req[1] = 1; add[1] = BASE + 32'hC; wen[1] = 1; be[1] = 4'hF;
        @(negedge clk);
        checks++; if (gnt[1] !== 1'b1) begin errors++; $display("FAIL rmid_gnt: got %b want 1", gnt[1]); end
        @(posedge clk); #1;
        req[1] = 0;
        rst = 1;
        @(negedge clk);
        checks++; if (rvalid[1] !== 1'b0 || mreq[1] !== 1'b0 || gnt[1] !== 1'b0) begin errors++; $display("FAIL rmid_outs: got rv %b mreq %b gnt %b want 0 0 0", rvalid[1], mreq[1], gnt[1]); end
        checks++; if (rdata[1] !== 32'h0 || opc[1] !== 1'b0) begin errors++; $display("FAIL rmid_rsp: got %h/%b want 0/0", rdata[1], opc[1]); end
        @(posedge clk); #1;
        rst = 0;
        seen_rv = 0; seen_mreq = 0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid[1]) seen_rv = 1;
            if (mreq[1]) seen_mreq = 1;
        end
        checks++; if (seen_rv !== 1'b0 || seen_mreq !== 1'b0) begin errors++; $display("FAIL rmid_dropped: got rv %b mreq %b want 0 0", seen_rv, seen_mreq); end
        txn(1, BASE + 32'hC, 1, 32'h0, 4'hF, 0);
        checks++; if (o_mreq !== 2 || o_rv !== 3) begin errors++; $display("FAIL rmid_fresh_lat: got mreq %0d rv %0d want 2 3", o_mreq, o_rv); end
        checks++; if (o_rdata !== ref_rd(1, BASE + 32'hC)) begin errors++; $display("FAIL rmid_fresh_data: got %h want %h", o_rdata, ref_rd(1, BASE + 32'hC)); end
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            req[g] = 0; add[g] = '0; wen[g] = 1; wdata[g] = '0; be[g] = '0;
        end
        repeat (2) @(posedge clk);
        test_reset();
        test_basic();
        test_wait();
        test_back_to_back();
        test_range();
        test_random();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
